// File: rtl/max7219_spi_rx.sv
// MAX7219-compatible SPI slave: oversamples cs/sclk/mosi on clk, assembles
// 16-bit address/data frames and keeps a shadow of the device register file.
module max7219_spi_rx #(
  parameter int ADDR_W     = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic [63:0]           rows,
  output logic [7:0]            decode_mode,
  output logic [3:0]            intensity,
  output logic [2:0]            scan_limit,
  output logic                  shutdown_n,
  output logic                  display_test,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic [FRAME_BITS-1:0] last_frame
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, COMMIT} state_t;

  state_t                state, state_nxt;
  logic [2:0]            cs_q, sclk_q;
  logic [1:0]            mosi_q;
  logic                  cs_s, cs_d, sclk_s, sclk_d, mosi_s;
  logic                  cs_fall, cs_rise, sclk_rise;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  clr, shift_en, commit, err;
  logic [ADDR_W-1:0]     addr;
  logic [7:0]            data;
  logic [7:0][7:0]       row_q;

  // cs sync resets low so a frame already in flight at reset release keeps
  // the FSM parked in WAIT_IDLE until cs is really seen high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q   <= '0;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], cs};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign cs_s      = cs_q[1];
  assign cs_d      = cs_q[2];
  assign sclk_s    = sclk_q[1];
  assign sclk_d    = sclk_q[2];
  assign mosi_s    = mosi_q[1];
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign sclk_rise = sclk_s & ~sclk_d;

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    err       = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_s) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          clr       = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = sclk_rise & ~cs_s;
        if (cs_rise) begin
          if (bit_cnt == CNT_W'(FRAME_BITS)) begin
            state_nxt = COMMIT;
          end else begin
            err       = (bit_cnt != '0);
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        commit = 1'b1;
        if (cs_fall) begin
          clr       = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  // Counter saturates so an over-long window commits its last 16 bits.
  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shreg <= {shreg[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt != CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign addr = shreg[8 +: ADDR_W];
  assign data = shreg[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q        <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
      last_frame   <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_error <= err;
      if (commit) begin
        last_frame <= shreg;
        for (int k = 0; k < 8; k++)
          if (addr == ADDR_W'(k + 1)) row_q[k] <= data;
        case (addr)
          ADDR_W'(9):  decode_mode  <= data;
          ADDR_W'(10): intensity    <= data[3:0];
          ADDR_W'(11): scan_limit   <= data[2:0];
          ADDR_W'(12): shutdown_n   <= data[0];
          ADDR_W'(15): display_test <= data[0];
          default: ;
        endcase
      end
    end
  end

  assign rows = row_q;

endmodule

// File: doc/max7219_spi_rx.md
# max7219_spi_rx

Receive-side counterpart of the LED-matrix SPI driver: a MAX7219-compatible SPI slave. It samples the cs/sclk/mosi lines produced by the matrix driver and assembles 16-bit frames (address byte, then data byte, MSB first). It decodes each frame into a shadow copy of the MAX7219 register file: 8 row registers plus control registers. Used as a loop-back checker on the board and as the bench model for the face-display path.

## Interface
- ADDR_W, 4, register address width taken from frame bits [11:8]; bits [15:12] are ignored.
- FRAME_BITS, 16, bits per frame; fixed, not to be overridden.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- cs  in  1  SPI chip select, active low; asynchronous to clk.
- sclk  in  1  SPI clock, mode 0; asynchronous to clk; high and low phases each ≥ 3 clk periods.
- mosi  in  1  SPI data; sampled on sclk rising edge.
- rows  out  64  row registers; rows[8*k+7:8*k] = digit register k+1 (addr 0x1..0x8).
- decode_mode  out  8  register 0x9.
- intensity  out  4  register 0xA, data[3:0].
- scan_limit  out  3  register 0xB, data[2:0].
- shutdown_n  out  1  register 0xC, data[0]; 0 = shutdown.
- display_test  out  1  register 0xF, data[0].
- frame_valid  out  1  one-clk pulse when a frame is committed.
- frame_error  out  1  one-clk pulse when cs deasserts after 1..15 bits.
- last_frame  out  16  most recently committed frame, including no-op frames.

## Operation
- Synchronizers: cs, sclk, and mosi each pass through 2 flops. A third flop on cs and sclk provides edge detection. All logic uses synchronized versions only.
- FSM states: WAIT_IDLE, IDLE, SHIFT, COMMIT.
  - WAIT_IDLE: entered at reset; moves to IDLE once synced cs = 1. This prevents a frame already in progress at reset release from being captured.
  - IDLE: on cs falling edge, clear shift register and bit counter, then go to SHIFT.
  - SHIFT: on each sclk rising edge, shift left: shreg <= {shreg[14:0], mosi_sync}. Bit counter increments, saturating at 16.
    - On cs rising edge with count = 16, go to COMMIT.
    - On cs rising edge with count 0, go to IDLE silently.
    - On cs rising edge with count 1..15, pulse frame_error and go to IDLE with no register change.
  - COMMIT: write the decoded register, set last_frame <= shreg, pulse frame_valid, go to IDLE.
- More than 16 bits in one cs window: the last 16 bits received are committed, as on the real device.
- Address decode on shreg[11:8]:
  - 0x0: no-op; only last_frame updates.
  - 0x1..0x8: rows.
  - 0x9..0xC and 0xF: the control registers listed in Interface.
  - 0xD and 0xE: ignored, but frame_valid still pulses.
- sclk edges while cs is high are ignored.
- A cs falling edge in the same cycle as COMMIT is not lost. COMMIT completes, then the FSM goes directly to SHIFT with the shift register and counter cleared.
- Reset values:
  - rows = 0, decode_mode = 0, intensity = 0, scan_limit = 0, last_frame = 0.
  - shutdown_n = 0, display_test = 0, frame_valid = 0, frame_error = 0.
  - FSM = WAIT_IDLE.
- Reset asserted mid-frame aborts the frame. The partial frame produces no commit and no frame_error.

## Timing
- Input-to-sync latency: 2 clk. Edge detect is valid on the 3rd clk after a pin transition is first sampled.
- Commit latency: registers, last_frame, and frame_valid update exactly 4 clk edges after the first clk edge that samples cs = 1 on the pin. That is 3 clk to detect the edge plus 1 for COMMIT.
- frame_error pulses 3 clk edges after cs rise is first sampled.
- frame_valid and frame_error are exactly 1 cycle wide and never asserted together.
- Output registers hold their value between commits.
- Minimum cs-high gap between frames: 4 clk.
- Throughput: 1 frame per (16 sclk periods + cs gap).

## Test plan
- Reset hold with no SPI traffic: all outputs at reset values.
- Frame 0x0C01: shutdown_n = 1, frame_valid pulses once, last_frame = 0x0C01.
- Full init sequence 0C01, 0900, 0A0A, 0B07, 0F00, then rows 0x013C..0x083C:
  - Required: intensity = 0xA, scan_limit = 7, decode_mode = 0, rows = 64'h3C3C3C3C3C3C3C3C.
- 8-bit frame (cs high after 0x0C): frame_error pulses 1 cycle, no register change, no frame_valid.
- 24-bit frame 0xFF_0342 in one cs window: rows[23:16] = 0x42, last_frame = 0x0342.
- Reset asserted after 10 bits of 0x0155, with cs still low at reset release, then a later 0x02AA frame:
  - Bits after release are ignored; no commit and no error.
  - The following 0x02AA frame gives rows[15:8] = 0xAA and rows[7:0] = 0.
